// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, keymap, debounce state encoding and
// the three-digit BCD to binary conversion.
package keypad_pkg;

  localparam int unsigned ADDR_W       = 9;
  localparam int unsigned MAX_ADDR_DEF = 511;

  // Key code = row*4 + col
  localparam logic [3:0] KEY_1     = 4'd0;
  localparam logic [3:0] KEY_2     = 4'd1;
  localparam logic [3:0] KEY_3     = 4'd2;
  localparam logic [3:0] KEY_A     = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_B     = 4'd7;
  localparam logic [3:0] KEY_7     = 4'd8;
  localparam logic [3:0] KEY_8     = 4'd9;
  localparam logic [3:0] KEY_9     = 4'd10;
  localparam logic [3:0] KEY_C     = 4'd11;
  localparam logic [3:0] KEY_STAR  = 4'd12;
  localparam logic [3:0] KEY_0     = 4'd13;
  localparam logic [3:0] KEY_HASH  = 4'd14;
  localparam logic [3:0] KEY_D     = 4'd15;

  localparam logic [1:0] ST_ARMED   = 2'd0;
  localparam logic [1:0] ST_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [2:0] {
    ACT_DIGIT, ACT_CLEAR, ACT_BACK, ACT_ENTER, ACT_NONE
  } key_act_e;

  typedef struct packed {
    key_act_e   act;
    logic [3:0] digit;
  } key_map_t;

  function automatic key_map_t keymap(input logic [3:0] code);
    key_map_t m;
    m.act   = ACT_DIGIT;
    m.digit = 4'd0;
    case (code)
      KEY_1:    m.digit = 4'd1;
      KEY_2:    m.digit = 4'd2;
      KEY_3:    m.digit = 4'd3;
      KEY_4:    m.digit = 4'd4;
      KEY_5:    m.digit = 4'd5;
      KEY_6:    m.digit = 4'd6;
      KEY_7:    m.digit = 4'd7;
      KEY_8:    m.digit = 4'd8;
      KEY_9:    m.digit = 4'd9;
      KEY_0:    m.digit = 4'd0;
      KEY_STAR: m.act   = ACT_CLEAR;
      KEY_B:    m.act   = ACT_BACK;
      KEY_HASH: m.act   = ACT_ENTER;
      default:  m.act   = ACT_NONE;
    endcase
    return m;
  endfunction

  function automatic logic [9:0] bcd3_to_bin(input logic [11:0] bcd);
    return 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanning, column synchronizer, per-frame contact decode and the
// press/release debounce FSM producing a one-cycle key_event.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

  logic [SLOT_W-1:0] slot;
  logic [1:0]        row;
  logic [3:0]        sync1, sync2;
  logic [1:0]        hits;
  logic [3:0]        hit_code;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;

  logic       slot_end, frame_end, frame_key;
  logic [1:0] row_hits, row_col, tot_hits;
  logic [3:0] cur_code;

  assign rows_n = ~(4'b0001 << row);

  // Contacts are saturated at 2 so MULTI is simply "more than one".
  always_comb begin
    row_hits = '0;
    row_col  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!sync2[c]) begin
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        row_col = 2'(c);
      end
    end
    tot_hits  = ((3'(hits) + 3'(row_hits)) >= 3'd2) ? 2'd2 : (hits + row_hits);
    cur_code  = (hits == 2'd1) ? hit_code : {row, row_col};
    slot_end  = (slot == SLOT_W'(SCAN_DIV - 1));
    frame_end = slot_end && (row == 2'd3);
    frame_key = frame_end && (tot_hits == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '1;
      sync2     <= '1;
      slot      <= '0;
      row       <= '0;
      hits      <= '0;
      hit_code  <= '0;
      state     <= ST_ARMED;
      cnt       <= '0;
      key_event <= 1'b0;
      key_code  <= '0;
    end else begin
      sync1     <= cols_n;
      sync2     <= sync1;
      key_event <= 1'b0;
      slot      <= slot_end ? '0 : slot + SLOT_W'(1);
      if (slot_end) begin
        row <= row + 2'd1;
        if (frame_end) begin
          hits <= '0;
        end else begin
          hits     <= tot_hits;
          hit_code <= cur_code;
        end
      end
      if (frame_end) begin
        case (state)
          ST_ARMED: if (frame_key) begin
            key_code <= cur_code;
            cnt      <= CNT_W'(1);
            state    <= ST_PRESS;
          end
          ST_PRESS: begin
            if (frame_key && cur_code == key_code) begin
              if (cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                key_event <= 1'b1;
                state     <= ST_HELD;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              state <= ST_ARMED;
            end
          end
          ST_HELD: if (!frame_key) begin
            cnt   <= CNT_W'(1);
            state <= ST_RELEASE;
          end
          default: begin
            if (frame_key) begin
              state <= ST_HELD;
            end else if (cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
              state <= ST_ARMED;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/address_entry_keypad.sv
// Keypad address entry: collects up to three decimal digits and converts
// them to a ROM address with a one-cycle valid or error strobe.
module address_entry_keypad
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned MAX_ADDR        = MAX_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cols_n,
  output logic [3:0]        rows_n,
  output logic [ADDR_W-1:0] address_line,
  output logic              address_valid,
  output logic              entry_error,
  output logic [11:0]       entry_bcd,
  output logic [1:0]        entry_count
);

  logic       key_event;
  logic [3:0] key_code;
  key_map_t   km;
  logic [9:0] value;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_scanner (
    .clk      (clk),
    .reset    (reset),
    .cols_n   (cols_n),
    .rows_n   (rows_n),
    .key_event(key_event),
    .key_code (key_code)
  );

  assign km    = keymap(key_code);
  assign value = bcd3_to_bin(entry_bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      address_line  <= '0;
      address_valid <= 1'b0;
      entry_error   <= 1'b0;
      entry_bcd     <= '0;
      entry_count   <= '0;
    end else begin
      address_valid <= 1'b0;
      entry_error   <= 1'b0;
      if (key_event) begin
        case (km.act)
          ACT_DIGIT: if (entry_count != 2'd3) begin
            entry_bcd   <= {entry_bcd[7:0], km.digit};
            entry_count <= entry_count + 2'd1;
          end
          ACT_BACK: if (entry_count != 2'd0) begin
            entry_bcd   <= {4'h0, entry_bcd[11:4]};
            entry_count <= entry_count - 2'd1;
          end
          ACT_CLEAR: begin
            entry_bcd   <= '0;
            entry_count <= '0;
          end
          ACT_ENTER: if (entry_count != 2'd0) begin
            if (value <= 10'(MAX_ADDR)) begin
              address_line  <= value[ADDR_W-1:0];
              address_valid <= 1'b1;
            end else begin
              entry_error <= 1'b1;
            end
            entry_bcd   <= '0;
            entry_count <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_address_entry_keypad.sv
// Scoreboard bench for address_entry_keypad: a keypad contact model drives
// cols_n from rows_n; every observable entry/address change is popped and checked.
module tb_address_entry_keypad;

  localparam int FRAME = 32;

  localparam int K1 = 0,  K2 = 1,  K3 = 2,  KA = 3;
  localparam int K4 = 4,  K5 = 5,  K6 = 6,  KB = 7;
  localparam int K7 = 8,  K8 = 9,  K9 = 10, KC = 11;
  localparam int KS = 12, K0 = 13, KH = 14, KD = 15;

  typedef struct packed {
    logic [11:0] bcd;
    logic [1:0]  cnt;
    logic        valid;
    logic        err;
    logic [8:0]  addr;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cols_n;
  logic [3:0]  rows_n;
  logic [8:0]  address_line;
  logic        address_valid;
  logic        entry_error;
  logic [11:0] entry_bcd;
  logic [1:0]  entry_count;
  logic [15:0] pressed = '0;

  int checks = 0;
  int failures = 0;
  snap_t exp_q[$];

  address_entry_keypad #(
    .SCAN_DIV       (8),
    .DEBOUNCE_FRAMES(4),
    .MAX_ADDR       (511)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cols_n       (cols_n),
    .rows_n       (rows_n),
    .address_line (address_line),
    .address_valid(address_valid),
    .entry_error  (entry_error),
    .entry_bcd    (entry_bcd),
    .entry_count  (entry_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    cols_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows_n[r] && pressed[r*4+c]) cols_n[c] = 1'b0;
  end

  // Monitor: any pulse or entry buffer change is one DUT output event.
  logic [13:0] prev_entry = '0;
  always @(negedge clk) begin
    snap_t act, exp;
    act = '{bcd: entry_bcd, cnt: entry_count, valid: address_valid,
            err: entry_error, addr: address_line};
    if (reset) begin
      prev_entry = {entry_bcd, entry_count};
    end else if (address_valid || entry_error || {entry_bcd, entry_count} != prev_entry) begin
      prev_entry = {entry_bcd, entry_count};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got bcd=%h cnt=%0d valid=%b err=%b addr=%0d, required no event",
                 act.bcd, act.cnt, act.valid, act.err, act.addr);
      end else begin
        exp = exp_q.pop_front();
        if (act != exp) begin
          failures++;
          $display("FAIL event: got bcd=%h cnt=%0d valid=%b err=%b addr=%0d, required bcd=%h cnt=%0d valid=%b err=%b addr=%0d",
                   act.bcd, act.cnt, act.valid, act.err, act.addr,
                   exp.bcd, exp.cnt, exp.valid, exp.err, exp.addr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input logic [11:0] bcd, input logic [1:0] cnt,
                            input logic v, input logic e, input logic [8:0] addr);
    exp_q.push_back('{bcd: bcd, cnt: cnt, valid: v, err: e, addr: addr});
  endtask

  task automatic tap(input int k);
    pressed[k] = 1'b1;
    repeat (6 * FRAME) @(posedge clk);
    pressed[k] = 1'b0;
    repeat (6 * FRAME) @(posedge clk);
  endtask

  task automatic key(input int k, input logic [11:0] bcd, input logic [1:0] cnt,
                     input logic v, input logic e, input logic [8:0] addr);
    expect_evt(bcd, cnt, v, e, addr);
    tap(k);
  endtask

  initial begin
    int wait_cyc;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rows_n", 32'(rows_n), 32'h e);
    check("reset_addr", 32'(address_line), 0);
    check("reset_valid", 32'(address_valid), 0);
    check("reset_error", 32'(entry_error), 0);
    check("reset_bcd", 32'(entry_bcd), 0);
    check("reset_count", 32'(entry_count), 0);

    // Single long hold: one event only
    key(K4, 12'h004, 2'd1, 0, 0, 9'd0);
    key(KS, 12'h000, 2'd0, 0, 0, 9'd0);

    key(K1, 12'h001, 2'd1, 0, 0, 9'd0);
    key(K2, 12'h012, 2'd2, 0, 0, 9'd0);
    key(K3, 12'h123, 2'd3, 0, 0, 9'd0);
    key(KH, 12'h000, 2'd0, 1, 0, 9'd123);

    key(K5, 12'h005, 2'd1, 0, 0, 9'd123);
    key(K1, 12'h051, 2'd2, 0, 0, 9'd123);
    key(K1, 12'h511, 2'd3, 0, 0, 9'd123);
    key(KH, 12'h000, 2'd0, 1, 0, 9'd511);
    key(K5, 12'h005, 2'd1, 0, 0, 9'd511);
    key(K1, 12'h051, 2'd2, 0, 0, 9'd511);
    key(K2, 12'h512, 2'd3, 0, 0, 9'd511);
    key(KH, 12'h000, 2'd0, 0, 1, 9'd511);

    key(K9, 12'h009, 2'd1, 0, 0, 9'd511);
    key(K8, 12'h098, 2'd2, 0, 0, 9'd511);
    key(KB, 12'h009, 2'd1, 0, 0, 9'd511);
    key(K7, 12'h097, 2'd2, 0, 0, 9'd511);
    key(KH, 12'h000, 2'd0, 1, 0, 9'd97);

    key(K1, 12'h001, 2'd1, 0, 0, 9'd97);
    key(K2, 12'h012, 2'd2, 0, 0, 9'd97);
    key(K3, 12'h123, 2'd3, 0, 0, 9'd97);
    tap(K4);
    tap(KA);
    @(negedge clk);
    check("full_buffer_bcd", 32'(entry_bcd), 32'h123);
    check("full_buffer_count", 32'(entry_count), 3);
    check("held_addr", 32'(address_line), 97);
    key(KS, 12'h000, 2'd0, 0, 0, 9'd97);
    tap(KH);
    tap(KB);

    // Bouncing contact, then steady
    for (int i = 0; i < (2 * FRAME) / 10; i++) begin
      pressed[K6] = ~pressed[K6];
      repeat (10) @(posedge clk);
    end
    expect_evt(12'h006, 2'd1, 0, 0, 9'd97);
    tap(K6);
    key(KS, 12'h000, 2'd0, 0, 0, 9'd97);

    // Two keys together: MULTI, no event
    pressed[K1] = 1'b1;
    pressed[K2] = 1'b1;
    repeat (6 * FRAME) @(posedge clk);
    pressed = '0;
    repeat (6 * FRAME) @(posedge clk);

    // Reset mid-entry while another key is being debounced
    key(K4, 12'h004, 2'd1, 0, 0, 9'd97);
    key(K2, 12'h042, 2'd2, 0, 0, 9'd97);
    pressed[K5] = 1'b1;
    repeat (2 * FRAME + 5) @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rows_n", 32'(rows_n), 32'h e);
    check("midreset_addr", 32'(address_line), 0);
    check("midreset_bcd", 32'(entry_bcd), 0);
    check("midreset_count", 32'(entry_count), 0);
    check("midreset_pulses", 32'({address_valid, entry_error}), 0);
    @(posedge clk);
    reset = 1'b0;
    expect_evt(12'h005, 2'd1, 0, 0, 9'd0);
    repeat (6 * FRAME) @(posedge clk);
    pressed = '0;
    repeat (6 * FRAME) @(posedge clk);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 2000) begin
      @(posedge clk);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/address_entry_keypad.md
Name: address_entry_keypad

Overview:
- Scans a 4x4 matrix keypad, debounces it, and accumulates up to three decimal digits.
- Converts the digits to a 9-bit binary ROM address (0..511) and presents it to the reader core with a one-cycle valid strobe.
- Acts as the input-side counterpart of the address display path: BCD to binary instead of binary to BCD.
- Drives entry_bcd so the display can echo the digits as they are typed.

Parameters:
- SCAN_DIV, 8: clocks per row slot; columns are sampled in the last cycle of the slot.
- DEBOUNCE_FRAMES, 4: consecutive identical scan frames needed to accept a press or a release.
- MAX_ADDR, 511: largest accepted address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cols_n  in  4  keypad column inputs, active-low, pulled up, asynchronous to clk
- rows_n  out  4  keypad row drive, one-hot active-low
- address_line  out  9  last accepted address, held until the next accept
- address_valid  out  1  one-cycle pulse when address_line is updated
- entry_error  out  1  one-cycle pulse when an entry is rejected as out of range
- entry_bcd  out  12  digits being typed: [11:8] hundreds, [7:4] tens, [3:0] ones
- entry_count  out  2  number of digits entered, 0..3

Behaviour:
- Reset values:
  - rows_n=4'b1110, address_line=0, address_valid=0, entry_error=0, entry_bcd=0, entry_count=0.
  - Debounce FSM goes to ARMED; slot counter and synchronizer are cleared.
- Reset mid-entry or mid-debounce discards all partial state. A key held through reset is accepted after a full debounce.
- Scan:
  - cols_n passes through a 2-flop synchronizer.
  - The row slot counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 the synchronized columns are sampled and rows_n rotates left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - One frame is 4 slots, 32 clocks at the defaults.
- Frame result: NONE if no column was low in any row; KEY(code=row*4+col) if exactly one contact was seen; otherwise MULTI, which is treated as NONE.
- Keymap:
  - row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = * 0 # D.
  - Digits 0-9 are digit keys. '*' is CLEAR, 'B' is BACKSPACE, '#' is ENTER. 'A', 'C' and 'D' are ignored.
- Debounce FSM (evaluated at each frame end):
  - ARMED: on KEY(k), latch k, cnt=1, go to PRESS. On NONE, stay.
  - PRESS:
    - Same k: cnt++.
    - When cnt reaches DEBOUNCE_FRAMES: emit a one-cycle key_event(k) and go to HELD.
    - Different key, or NONE: return to ARMED.
  - HELD: on NONE, cnt=1, go to RELEASE. Otherwise stay; there is no auto-repeat.
  - RELEASE:
    - On NONE, cnt++; reaching DEBOUNCE_FRAMES goes to ARMED.
    - Any KEY: return to HELD.
- Entry actions, applied on the key_event cycle and visible on entry_bcd/entry_count the next clock:
  - Digit d:
    - If count<3: entry_bcd <= {entry_bcd[7:0], d}, count++.
    - If count==3: ignored, buffer unchanged.
  - BACKSPACE:
    - If count>0: entry_bcd <= {4'h0, entry_bcd[11:4]}, count--.
    - If count==0: no-op.
  - CLEAR: entry_bcd=0, count=0.
  - ENTER:
    - If count==0: no-op, no pulse.
    - Otherwise compute value = h*100 + t*10 + o (10-bit intermediate, range 0..999).
    - If value<=MAX_ADDR: address_line <= value[8:0] and address_valid=1 on the next clock.
    - Else: entry_error=1 on the next clock, and address_line is unchanged.
    - In both cases the buffer and count clear.
- address_valid and entry_error are never high in the same cycle. Each is high for exactly one clock per ENTER.
- Latency from ENTER key_event to address_valid is 1 clock. From a physical press to key_event it is between DEBOUNCE_FRAMES and DEBOUNCE_FRAMES+1 frames, plus 2 synchronizer clocks.

Decomposition:
- keypad_pkg holds:
  - KEY_* codes and the keymap function;
  - debounce state encoding (ARMED, PRESS, HELD, RELEASE);
  - ADDR_W=9 and MAX_ADDR default;
  - the bcd3_to_bin function.
- Sub-module keypad_scanner contains row rotation, synchronizer, frame decode and the debounce FSM. It outputs key_event and key_code.
- The top level holds the entry buffer, BCD-to-binary conversion and the output registers.

Test Plan:
- Hold key '4' (row1, col0) for 6 frames, then release -> exactly one key_event; entry_bcd=12'h004, entry_count=1; no second event while held.
- Press 1,2,3 then '#' -> address_valid high for 1 clock, address_line=123 (9'h07B); entry_bcd=0, count=0.
- Press 5,1,1,'#' -> address_line=511 with valid. Then press 5,1,2,'#' -> entry_error pulse, address_line stays 511, no valid.
- Press 9,8,'B',7,'#' -> address_line=97. Also press 1,2,3,4 -> entry_bcd=12'h123 (fourth digit ignored). Then '*' -> bcd=0, count=0.
- Bounce: toggle the '6' contact every 10 clocks for 2 frames, then hold steady -> only one event, and only after 4 stable frames. Press '1' and '2' together -> no event.
- Assert reset during PRESS with digits 4,2 entered -> all outputs at reset values next clock, rows_n=4'b1110. A held key is accepted after a full debounce.
